// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage core.
// Contents: IF/ID flush codes, NOP opcode, zero-register index and the
// mult/div busy-timer state encoding.
package pipe_pkg;

  localparam logic [1:0] FLUSH_NONE   = 2'b00;
  localparam logic [1:0] FLUSH_JUMP   = 2'b01;
  localparam logic [1:0] FLUSH_BRANCH = 2'b10;

  localparam logic [5:0] OP_NOP   = 6'b111111;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: tracks how long HI/LO stay invalid after a
// mult/div issues.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      mult/div issues this cycle (only honoured in IDLE)
//   busy       HI/LO result pending
//
// state   | meaning
// --------+-------------------------------------------------------
// MD_IDLE | no mult/div in flight, HI/LO valid
// MD_BUSY | mult/div in flight, countdown running toward 0
module md_busy_timer #(
  parameter int MD_LATENCY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);
  import pipe_pkg::*;

  localparam int TW = $clog2(MD_LATENCY);
  localparam logic [TW-1:0] CNT_LOAD = TW'(MD_LATENCY - 1);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);

  md_state_e     state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The issue cycle counts as the first latency cycle, so BUSY lasts
  // MD_LATENCY-1 cycles and HI/LO are usable at issue+MD_LATENCY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush controller.
// Resolves load-use hazards, HI/LO dependencies on the mult/div unit and
// control redirects (jumps in ID, taken branches in EX).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_rs, id_rt        source fields of the ID instruction
//   id_uses_rt          ID instruction reads rt
//   id_jump             ID instruction is j/jal/jr
//   id_md_start         ID instruction is mult/div
//   id_reads_hilo       ID instruction is mfhi/mflo
//   ex_mem_read, ex_rt  EX instruction is a load and its destination
//   ex_branch_taken     EX branch resolved taken
//   pc_write_en         PC may update
//   freeze              hold IF/ID
//   flush               IF/ID kill code (none/jump/branch)
//   idex_bubble         insert NOP into ID/EX
//   md_busy             mult/div result pending
//   stall_cycles        saturating count of frozen cycles
module hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_md_start,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_write_en,
  output logic             freeze,
  output logic [1:0]       flush,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);
  import pipe_pkg::*;

  logic             load_use;
  logic             md_hazard;
  logic             md_issue;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign md_hazard = md_busy && (id_reads_hilo || id_md_start);

  // A mult/div only issues if the ID instruction is neither killed by a
  // branch nor held by a stall.
  assign md_issue = id_md_start && !ex_branch_taken && !load_use && !md_hazard;

  md_busy_timer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_busy_timer (
    .clk  (clk),
    .rst  (rst),
    .start(md_issue),
    .busy (md_busy)
  );

  // Branch outranks stalls so that freeze and flush are never active
  // together; a flush during freeze would be dropped by IF/ID.
  always_comb begin
    pc_write_en = 1'b1;
    freeze      = 1'b0;
    flush       = FLUSH_NONE;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_write_en = 1'b0;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      flush       = FLUSH_BRANCH;
      idex_bubble = 1'b1;
    end else if (load_use || md_hazard) begin
      freeze      = 1'b1;
      pc_write_en = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_jump) begin
      flush = FLUSH_JUMP;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (freeze && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;

endmodule
